// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C transaction engine between two config
// sequencers, with a bus-free gap after every transaction and a completion timeout.
module i2c_master_arbiter #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int GAP_CYC     = 25
) (
    input  logic        CLK_50,
    input  logic        RESET_N,

    input  logic        A_REQ,
    input  logic        A_RNW,
    input  logic [7:0]  A_SLAVE_ADDR,
    input  logic [15:0] A_POINTER,
    input  logic [15:0] A_WDATA,
    output logic        A_GNT,
    output logic        A_DONE,
    output logic        A_ERR,
    output logic [15:0] A_RDATA,

    input  logic        B_REQ,
    input  logic        B_RNW,
    input  logic [7:0]  B_SLAVE_ADDR,
    input  logic [15:0] B_POINTER,
    input  logic [15:0] B_WDATA,
    output logic        B_GNT,
    output logic        B_DONE,
    output logic        B_ERR,
    output logic [15:0] B_RDATA,

    output logic        M_GO,
    output logic        M_RNW,
    output logic [7:0]  M_SLAVE_ADDR,
    output logic [15:0] M_POINTER,
    output logic [15:0] M_WDATA,
    input  logic        M_DONE,
    input  logic        M_ACK_OK,
    input  logic [15:0] M_RDATA,
    output logic        M_ABORT,

    output logic        BUSY,
    output logic [1:0]  ST
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] tmo_cnt;
    logic [15:0] gap_cnt;
    logic        last_b;

    logic pick_a;
    logic pick_b;
    logic tmo_hit;
    logic go_nx;
    logic done_nx;
    logic err_nx;
    logic abort_nx;
    logic rd_upd;

    // On a tie the requester that did not win last time is chosen.
    assign pick_a  = A_REQ && (!B_REQ || last_b);
    assign pick_b  = B_REQ && (!A_REQ || !last_b);
    assign tmo_hit = (tmo_cnt + 32'd1) == TMO_LAST;

    assign BUSY = (state != S_IDLE);
    assign ST   = state;

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pick_a || pick_b) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (M_DONE || tmo_hit) state_nx = S_GAP;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // M_DONE beats a timeout landing in the same cycle, so no abort is raised then.
    always_comb begin
        go_nx    = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        abort_nx = 1'b0;
        rd_upd   = 1'b0;
        case (state)
            S_ISSUE: go_nx = 1'b1;
            S_WAIT: begin
                done_nx  = M_DONE || tmo_hit;
                err_nx   = M_DONE ? !M_ACK_OK : tmo_hit;
                abort_nx = !M_DONE && tmo_hit;
                rd_upd   = M_DONE && M_RNW;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            last_b       <= 1'b1;
            A_GNT        <= 1'b0;
            B_GNT        <= 1'b0;
            A_DONE       <= 1'b0;
            B_DONE       <= 1'b0;
            A_ERR        <= 1'b0;
            B_ERR        <= 1'b0;
            A_RDATA      <= '0;
            B_RDATA      <= '0;
            M_GO         <= 1'b0;
            M_ABORT      <= 1'b0;
            M_RNW        <= 1'b0;
            M_SLAVE_ADDR <= '0;
            M_POINTER    <= '0;
            M_WDATA      <= '0;
        end else begin
            M_GO    <= go_nx;
            M_ABORT <= abort_nx;
            A_DONE  <= done_nx && !last_b;
            B_DONE  <= done_nx && last_b;
            A_ERR   <= err_nx && !last_b;
            B_ERR   <= err_nx && last_b;
            case (state)
                S_IDLE: begin
                    if (pick_a) begin
                        M_RNW        <= A_RNW;
                        M_SLAVE_ADDR <= A_SLAVE_ADDR;
                        M_POINTER    <= A_POINTER;
                        M_WDATA      <= A_WDATA;
                        A_GNT        <= 1'b1;
                        last_b       <= 1'b0;
                    end else if (pick_b) begin
                        M_RNW        <= B_RNW;
                        M_SLAVE_ADDR <= B_SLAVE_ADDR;
                        M_POINTER    <= B_POINTER;
                        M_WDATA      <= B_WDATA;
                        B_GNT        <= 1'b1;
                        last_b       <= 1'b1;
                    end
                end
                S_ISSUE: tmo_cnt <= '0;
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (done_nx) begin
                        A_GNT   <= 1'b0;
                        B_GNT   <= 1'b0;
                        gap_cnt <= '0;
                    end
                    if (rd_upd) begin
                        if (last_b) B_RDATA <= M_RDATA;
                        else        A_RDATA <= M_RDATA;
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule
